muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU in cycles (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge active.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  E-stage mult/div issue strobe, one cycle per instruction.
REQ-006 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL have port a  input  32  rs operand (multiplicand/dividend).
REQ-008 SHALL have port b  input  32  rt operand (multiplier/divisor).
REQ-009 SHALL have port hi_we  input  1  MTHI write strobe.
REQ-010 SHALL have port lo_we  input  1  MTLO write strobe.
REQ-011 SHALL have port wdata  input  32  MTHI/MTLO data.
REQ-012 SHALL have port busy  output  1  unit computing; pipeline stall source.
REQ-013 SHALL have port hi  output  32  HI register, read by MFHI.
REQ-014 SHALL have port lo  output  32  LO register, read by MFLO.

Function
REQ-015 SHALL implement two states: IDLE and BUSY.
REQ-016 IDLE + start=1 SHALL: capture a, b and op, compute the full result, load a 4-bit counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY at that edge.
REQ-017 busy SHALL equal 1 exactly while in BUSY, i.e. for N cycles starting the cycle after start.
REQ-018 The counter SHALL decrement by one each BUSY cycle.
REQ-019 On the edge where the counter reaches 1, the block SHALL write the result to hi/lo and return to IDLE; busy SHALL be 0 in the following cycle.
REQ-020 MULT SHALL produce the signed 64-bit product; MULTU the unsigned product; {hi,lo} = product[63:0].
REQ-021 DIV SHALL write lo = signed quotient, truncated toward zero, and hi = remainder carrying the sign of the dividend.
REQ-022 DIVU SHALL write the unsigned quotient to lo and the unsigned remainder to hi.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-024 Divide by zero (b=0) SHALL run the full DIV_CYCLES with busy asserted, then leave hi/lo unchanged.
REQ-025 start, hi_we and lo_we SHALL be ignored while in BUSY (the pipeline guarantees none are issued then).
REQ-026 IDLE + hi_we SHALL write hi=wdata at that edge; IDLE + lo_we SHALL write lo=wdata; both may be set in the same cycle.
REQ-027 IDLE + start together with hi_we/lo_we SHALL give start priority; the writes SHALL be discarded.
REQ-028 hi/lo SHALL hold their value across BUSY until the commit edge, so MFHI/MFLO during BUSY return the old values.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, counter=0, busy=0, hi=0 and lo=0, including mid-operation (the in-flight result is discarded).
REQ-030 After reset deasserts, the first rising edge with start=1 SHALL begin a new operation normally.

Structure
REQ-031 A shared package md_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the default latency constants.
REQ-032 The control FSM, counter and arithmetic SHALL all reside in muldiv_ctrl; no sub-module is required.
REQ-033 The arithmetic result SHALL be registered at issue into a 64-bit pending register, not recomputed at commit.

Verification
REQ-034 MULT a=0xFFFFFFFE(-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 DIV a=-7, b=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-037 MTHI 0x12345678, then DIVU b=0 -> busy 10 cycles; hi stays 0x12345678 and lo is unchanged.
REQ-038 Same-cycle start(MULT 3*4) with hi_we(0xAAAA) -> hi=0, lo=12 after commit; a start pulse during BUSY is ignored.
REQ-039 reset asserted in the 3rd DIV busy cycle -> busy=0, hi=lo=0 immediately, with no commit afterwards.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation encodings,
// controller states and the default busy latencies.
package md_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers. The result is
// computed at issue, held in a pending register, and committed after a fixed latency.
module muldiv_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        skip_q, skip_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    md_op_e      op_e;
    logic        is_div;
    logic [63:0] prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
    logic [63:0] result;

    assign op_e   = md_op_e'(op);
    assign is_div = (op_e == OP_DIV) || (op_e == OP_DIVU);

    // Signed product via sign-extended 64-bit operands; low 64 bits are exact.
    always_comb begin
        if (op_e == OP_MULT)
            prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else
            prod = {32'd0, a} * {32'd0, b};
    end

    // Signed division through magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        a_neg  = (op_e == OP_DIV) && a[31];
        b_neg  = (op_e == OP_DIV) && b[31];
        a_mag  = a_neg ? (~a + 32'd1) : a;
        b_mag  = (b == 32'd0) ? 32'd1 : (b_neg ? (~b + 32'd1) : b);
        q_mag  = a_mag / b_mag;
        r_mag  = a_mag % b_mag;
        quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
        result = is_div ? {rem, quot} : prod;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        skip_d  = skip_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pend_d  = result;
                    skip_d  = is_div && (b == 32'd0);
                    cnt_d   = is_div ? DIV_CYCLES[3:0] : MULT_CYCLES[3:0];
                    state_d = ST_BUSY;
                    busy_d  = 1'b1;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (!skip_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 64'd0;
            skip_q  <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            skip_q  <= skip_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed scenarios with literal results plus a random run,
// all tracked cycle by cycle against a behavioural HI/LO model.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;

    muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Behavioural model: cycles left until commit, architectural HI/LO, pending result.
    int          m_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_skip;

    task automatic model_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rh, output logic [31:0] rl, output bit sk);
        longint sx, sy, ux, uy, p;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        sk = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            2'b00: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
            2'b01: begin p = ux * uy; rh = p[63:32]; rl = p[31:0]; end
            2'b10: begin
                if (y == 0) sk = 1'b1;
                else begin p = sx / sy; rl = p[31:0]; p = sx % sy; rh = p[31:0]; end
            end
            default: begin
                if (y == 0) sk = 1'b1;
                else begin rl = x / y; rh = x % y; end
            end
        endcase
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left = 0;
            m_hi = '0;
            m_lo = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && !p_skip) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (start) begin
            model_result(op, a, b, p_hi, p_lo, p_skip);
            m_left = op[1] ? 10 : 5;
        end else begin
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("model_busy", {31'd0, busy}, {31'd0, m_left > 0});
            check("model_hi", hi, m_hi);
            check("model_lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic hw, input logic lw, input logic [31:0] wd);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; hi_we = hw; lo_we = lw; wdata = wd;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        $display("issue op=%0d a=%08h b=%08h hi_we=%0b lo_we=%0b", o, x, y, hw, lw);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) check("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    int n;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b1;

        issue(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 32'd0);
        wait_idle(n);
        check("mult_len", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        issue(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'd0);
        wait_idle(n);
        check("multu_len", n, 32'd5);
        check("multu_hi", hi, 32'h1);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0);
        wait_idle(n);
        check("div_len", n, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(2'b11, 32'd7, 32'd2, 1'b0, 1'b0, 32'd0);
        wait_idle(n);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        wait_idle(n);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'h0);

        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", hi, 32'h1234_5678);
        issue(2'b11, 32'd99, 32'd0, 1'b0, 1'b0, 32'd0);
        wait_idle(n);
        check("div0_len", n, 32'd10);
        check("div0_hi", hi, 32'h1234_5678);
        check("div0_lo", lo, 32'h8000_0000);

        issue(2'b00, 32'd3, 32'd4, 1'b1, 1'b0, 32'h0000_AAAA);
        check("prio_old_hi", hi, 32'h1234_5678);
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        check("prio_len", n, 32'd4);
        check("prio_hi", hi, 32'h0);
        check("prio_lo", lo, 32'd12);

        issue(2'b10, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("arst_nocommit_lo", lo, 32'h0);

        issue(2'b01, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0);
        wait_idle(n);
        check("post_rst_len", n, 32'd5);
        check("post_rst_lo", lo, 32'd42);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            op = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            hi_we = ($urandom_range(0, 3) == 0);
            lo_we = ($urandom_range(0, 3) == 0);
            wdata = $urandom;
            if (start && m_left == 0)
                $display("rand issue op=%0d a=%08h b=%08h", op, a, b);
        end
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
